// File: rtl/rvfi_dmem_pkg.sv
// rtl/rvfi_dmem_pkg.sv - shared types and address helpers for the RVFI data-memory responder.
package rvfi_dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   // BYTES = XLEN/8
   function automatic int bytes_of(input int xlen);
      return xlen / 8;
   endfunction

   // IDX_W = log2(DEPTH)
   function automatic int idx_w_of(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Drops byte-offset bits and everything above the word index, so addresses alias modulo DEPTH words.
   function automatic logic [63:0] word_index(input logic [63:0] addr, input int xlen, input int depth);
      return (addr >> $clog2(xlen / 8)) & ((64'd1 << idx_w_of(depth)) - 64'd1);
   endfunction

endpackage

// File: rtl/rvfi_dmem_ram.sv
// rtl/rvfi_dmem_ram.sv - byte-strobed shadow RAM with per-byte written flags and read-before-write port.
module rvfi_dmem_ram
   import rvfi_dmem_pkg::*;
#(
   parameter int         XLEN      = 32,
   parameter int         DEPTH     = 64,
   parameter logic [7:0] INIT_BYTE = 8'h00
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic [idx_w_of(DEPTH)-1:0]  idx,
   input  logic                        we,
   input  logic [bytes_of(XLEN)-1:0]   wstrb,
   input  logic [XLEN-1:0]             wdata,
   output logic [XLEN-1:0]             rdata
);

   localparam int NB = bytes_of(XLEN);

   logic [XLEN-1:0] mem     [DEPTH];
   logic [NB-1:0]   written [DEPTH];

   // Never-written bytes read as INIT_BYTE regardless of the underlying storage.
   always_comb begin
      rdata = '0;
      for (int b = 0; b < NB; b++) begin
         rdata[8*b +: 8] = written[idx][b] ? mem[idx][8*b +: 8] : INIT_BYTE;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < NB; b++) begin
            if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) written[i] <= '0;
      end else if (we) begin
         for (int b = 0; b < NB; b++) begin
            if (wstrb[b]) written[idx][b] <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/rvfi_dmem_responder.sv
// rtl/rvfi_dmem_responder.sv - data-memory slave with programmable latency, stall and backpressure.
// Optional range check / rsp_err output enabled by RISCV_FORMAL_DMEM_ERR_EN.
module rvfi_dmem_responder
   import rvfi_dmem_pkg::*;
#(
   parameter int         XLEN      = 32,
   parameter int         DEPTH     = 64,
   parameter int         LATENCY   = 2,
   parameter logic [7:0] INIT_BYTE = 8'h00
`ifdef RISCV_FORMAL_DMEM_ERR_EN
   , parameter longint unsigned LIMIT = DEPTH * XLEN / 8
`endif
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [XLEN-1:0]           req_addr,
   input  logic [bytes_of(XLEN)-1:0] req_wstrb,
   input  logic [XLEN-1:0]           req_wdata,
   input  logic                      stall,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [XLEN-1:0]           rsp_rdata,
`ifdef RISCV_FORMAL_DMEM_ERR_EN
   output logic                      rsp_err,
`endif
   output logic                      busy
);

   localparam int IW    = idx_w_of(DEPTH);
   localparam int CNT_W = $clog2(LATENCY + 1);

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [IW-1:0]      idx;
   logic [XLEN-1:0]    ram_rdata;
   logic               wr_en;
   logic               accept;
   logic               in_range;

   assign idx  = IW'(word_index(64'(req_addr), XLEN, DEPTH));
   assign busy = (state != IDLE);

`ifdef RISCV_FORMAL_DMEM_ERR_EN
   assign in_range = (64'(req_addr) < 64'(LIMIT));
`else
   assign in_range = 1'b1;
`endif

   rvfi_dmem_ram #(
      .XLEN      (XLEN),
      .DEPTH     (DEPTH),
      .INIT_BYTE (INIT_BYTE)
   ) u_ram (
      .clk    (clk),
      .resetn (resetn),
      .idx    (idx),
      .we     (wr_en),
      .wstrb  (req_wstrb),
      .wdata  (req_wdata),
      .rdata  (ram_rdata)
   );

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      wr_en     = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept   = 1'b1;
               wr_en    = in_range;
               cnt_nx   = CNT_W'(LATENCY - 1);
               state_nx = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (!stall) begin
               cnt_nx = cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state_nx = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Response data is captured at acceptance (pre-write contents) and held until the handshake.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         cnt       <= '0;
         rsp_rdata <= '0;
`ifdef RISCV_FORMAL_DMEM_ERR_EN
         rsp_err   <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) begin
            rsp_rdata <= in_range ? ram_rdata : '0;
`ifdef RISCV_FORMAL_DMEM_ERR_EN
            rsp_err   <= !in_range;
`endif
         end
      end
   end

endmodule

// File: tb/tb_rvfi_dmem_responder.sv
// tb/tb_rvfi_dmem_responder.sv - directed scoreboard bench for rvfi_dmem_responder (RISCV_FORMAL_DMEM_ERR_EN aware).
module tb_rvfi_dmem_responder;

   localparam int         XLEN  = 32;
   localparam int         DEPTH = 64;
   localparam int         LAT   = 3;
   localparam logic [7:0] INIT  = 8'h00;
   localparam logic [31:0] LIMIT_ADDR = 32'h100;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [3:0]  req_wstrb = '0;
   logic [31:0] req_wdata = '0;
   logic        stall = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        busy;
`ifdef RISCV_FORMAL_DMEM_ERR_EN
   logic        rsp_err;
`endif

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t sb[$];

   logic [7:0] mem_m [DEPTH][4];
   bit         wr_m  [DEPTH][4];

   rvfi_dmem_responder #(
      .XLEN      (XLEN),
      .DEPTH     (DEPTH),
      .LATENCY   (LAT),
      .INIT_BYTE (INIT)
`ifdef RISCV_FORMAL_DMEM_ERR_EN
      , .LIMIT   (64'(LIMIT_ADDR))
`endif
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_wstrb (req_wstrb),
      .req_wdata (req_wdata),
      .stall     (stall),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
`ifdef RISCV_FORMAL_DMEM_ERR_EN
      .rsp_err   (rsp_err),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int w = 0; w < DEPTH; w++)
         for (int b = 0; b < 4; b++) wr_m[w][b] = 1'b0;
   endtask

   function automatic exp_t model_access(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      exp_t r;
      int   w;
      w = int'((a >> 2) % DEPTH);
      r.rdata = '0;
      r.err   = 1'b0;
`ifdef RISCV_FORMAL_DMEM_ERR_EN
      if (a >= LIMIT_ADDR) begin
         r.err = 1'b1;
         return r;
      end
`endif
      for (int b = 0; b < 4; b++) r.rdata[8*b +: 8] = wr_m[w][b] ? mem_m[w][b] : INIT;
      for (int b = 0; b < 4; b++) begin
         if (s[b]) begin
            mem_m[w][b] = d[8*b +: 8];
            wr_m[w][b]  = 1'b1;
         end
      end
      return r;
   endfunction

   // One transaction: drive, predict, wait (bounded) for the response, check latency/data/stability, handshake.
   task automatic do_req(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data,
                         input int nstall, input int nbp, input bit hold, input logic [31:0] hold_addr);
      exp_t        e;
      int          acc;
      int          k;
      bit          ok_ready;
      bit          ok_stable;
      logic [31:0] got;
      @(negedge clk);
      for (int n = 0; n < 50; n++) begin
         if (req_ready) break;
         @(negedge clk);
      end
      check("req_ready_idle", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_addr  = addr;
      req_wstrb = strb;
      req_wdata = data;
      sb.push_back(model_access(addr, strb, data));
      @(posedge clk);
      #1;
      acc = cyc;
      if (hold) begin
         req_addr  = hold_addr;
         req_wstrb = '0;
      end else begin
         req_valid = 1'b0;
      end
      k = 0;
      ok_ready = 1'b1;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (rsp_valid) break;
         if (req_ready) ok_ready = 1'b0;
         k++;
         stall = (k <= nstall);
      end
      stall = 1'b0;
      check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("latency", 32'(cyc - acc + 1), 32'(LAT + nstall));
      e = sb.pop_front();
      check("rdata", rsp_rdata, e.rdata);
`ifdef RISCV_FORMAL_DMEM_ERR_EN
      check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
`endif
      ok_stable = 1'b1;
      got = rsp_rdata;
      for (int n = 0; n < nbp; n++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_rdata !== got) ok_stable = 1'b0;
         if (req_ready) ok_ready = 1'b0;
      end
      check("req_ready_low", {31'b0, ok_ready}, 32'd1);
      if (nbp > 0) check("rdata_stable", {31'b0, ok_stable}, 32'd1);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      model_clear();
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_rdata", rsp_rdata, 32'h0);

      do_req(32'h10, 4'b0000, 32'h0, 0, 0, 1'b0, 32'h0);
      do_req(32'h20, 4'b1111, 32'hDEADBEEF, 0, 0, 1'b0, 32'h0);
      do_req(32'h20, 4'b0000, 32'h0, 0, 0, 1'b0, 32'h0);
      do_req(32'h24, 4'b0101, 32'h11223344, 0, 0, 1'b0, 32'h0);
      do_req(32'h24, 4'b0000, 32'h0, 0, 0, 1'b0, 32'h0);

      // Stall + backpressure with a read held on req_valid behind it.
      do_req(32'h30, 4'b1111, 32'hCAFEF00D, 2, 3, 1'b1, 32'h30);
      do_req(32'h30, 4'b0000, 32'h0, 0, 0, 1'b0, 32'h0);

      do_req(32'h000, 4'b1111, 32'hA5A5A5A5, 0, 0, 1'b0, 32'h0);
      do_req(32'h100, 4'b0000, 32'h0, 0, 1, 1'b0, 32'h0);

      // Reset while in WAIT aborts the transaction and forgets RAM contents.
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = 32'h000;
      req_wstrb = 4'b0000;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("busy_in_wait", {31'b0, busy}, 32'd1);
      resetn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
      resetn = 1'b1;
      model_clear();
      do_req(32'h000, 4'b0000, 32'h0, 0, 0, 1'b0, 32'h0);

      // Out-of-range write (or alias of 0x004 when the range check is absent), then read 0x004.
      do_req(32'h004, 4'b1111, 32'h12345678, 0, 0, 1'b0, 32'h0);
      do_req(32'h104, 4'b1111, 32'hFFFFFFFF, 0, 0, 1'b0, 32'h0);
      do_req(32'h004, 4'b0000, 32'h0, 0, 0, 1'b0, 32'h0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
